// File: rtl/i2c_master_host_regs.sv
// i2c_master_host_regs: host register bank, TX byte FIFO and RX capture path
// in front of the I2C master top. Single clock, synchronous active-high reset.
// Optional feature macro: I2C_HOST_RX_FIFO_EN selects an RX_DEPTH-entry RX FIFO
// instead of the default single holding register.
module i2c_master_host_regs #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] bus_addr,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rvalid,
    output logic [7:0] config_reg,
    output logic [7:0] mode_reg,
    output logic [9:0] slave_addr_reg,
    output logic [7:0] byte_cnt_reg,
    output logic [7:0] transmit_data,
    input  logic       tx_byte_taken,
    input  logic [7:0] received_data,
    input  logic       rx_byte_valid,
    input  logic [7:0] cmd_status_reg,
    input  logic       start_ack
);

    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int TXCW = TXAW + 1;

    localparam logic [2:0] A_CONFIG = 3'd0;
    localparam logic [2:0] A_MODE   = 3'd1;
    localparam logic [2:0] A_SADRL  = 3'd2;
    localparam logic [2:0] A_FLAGS  = 3'd3;
    localparam logic [2:0] A_BCNT   = 3'd4;
    localparam logic [2:0] A_TXDATA = 3'd5;
    localparam logic [2:0] A_RXDATA = 3'd6;
    localparam logic [2:0] A_STATUS = 3'd7;

    // Both FIFOs rely on pointers wrapping naturally at a power-of-2 depth.
    if ((TX_DEPTH < 2) || ((TX_DEPTH & (TX_DEPTH - 1)) != 0) ||
        (RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("TX_DEPTH and RX_DEPTH must be powers of 2 and >= 2");
    end

    // Register bank state
    logic [7:0] cfg_q, cfg_d;
    logic [7:0] mode_q, mode_d;
    logic [9:0] sadr_q, sadr_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       rx_ovf_q, rx_ovf_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       tx_unf_q, tx_unf_d;

    // TX FIFO state
    logic [TX_DEPTH-1:0][7:0] tx_mem_q, tx_mem_d;
    logic [TXAW-1:0]          tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [TXCW-1:0]          tx_cnt_q, tx_cnt_d;

`ifdef I2C_HOST_RX_FIFO_EN
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int RXCW = RXAW + 1;
    logic [RX_DEPTH-1:0][7:0] rx_mem_q, rx_mem_d;
    logic [RXAW-1:0]          rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [RXCW-1:0]          rx_cnt_q, rx_cnt_d;
    logic                     rx_push, rx_pop;
`else
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_vld_q, rx_vld_d;
`endif

    logic       wr_en, rd_en;
    logic       tx_full, tx_empty, tx_push_req, tx_push, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_pop_req;
    logic [7:0] rx_head;

    assign wr_en       = bus_wr;
    assign rd_en       = bus_rd && !bus_wr;   // a coincident write suppresses the read
    assign tx_full     = (tx_cnt_q == TXCW'(TX_DEPTH));
    assign tx_empty    = (tx_cnt_q == '0);
    assign tx_head     = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
    assign tx_push_req = wr_en && (bus_addr == A_TXDATA);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign tx_push     = tx_push_req && (!tx_full || tx_byte_taken);
    assign tx_pop      = tx_byte_taken && !tx_empty;
    assign rx_pop_req  = rd_en && (bus_addr == A_RXDATA);

`ifdef I2C_HOST_RX_FIFO_EN
    assign rx_full  = (rx_cnt_q == RXCW'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
    assign rx_push  = rx_byte_valid && (!rx_full || rx_pop_req);
    assign rx_pop   = rx_pop_req && !rx_empty;
`else
    assign rx_full  = rx_vld_q;
    assign rx_empty = !rx_vld_q;
    assign rx_head  = rx_byte_q;
`endif

    assign config_reg     = cfg_q;
    assign mode_reg       = mode_q;
    assign slave_addr_reg = sadr_q;
    assign byte_cnt_reg   = bcnt_q;
    assign transmit_data  = tx_head;
    assign bus_rdata      = rdata_q;
    assign bus_rvalid     = rvalid_q;

    // Next-state: register writes, hardware clears, FIFO bookkeeping, read mux
    always_comb begin
        cfg_d    = cfg_q;
        mode_d   = mode_q;
        sadr_d   = sadr_q;
        bcnt_d   = bcnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        tx_unf_d = tx_unf_q;
        tx_mem_d = tx_mem_q;
        tx_rd_d  = tx_rd_q;
        tx_wr_d  = tx_wr_q;
        tx_cnt_d = tx_cnt_q;
`ifdef I2C_HOST_RX_FIFO_EN
        rx_mem_d = rx_mem_q;
        rx_rd_d  = rx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_cnt_d = rx_cnt_q;
`else
        rx_byte_d = rx_byte_q;
        rx_vld_d  = rx_vld_q;
`endif

        // INT_CLR is a one-cycle pulse; START drops after the master acks it.
        if (cfg_q[1]) cfg_d[1] = 1'b0;
        if (start_ack) cfg_d[0] = 1'b0;

        // Sticky flag clears come first so a same-cycle event still sets the flag.
        if (wr_en) begin
            case (bus_addr)
                A_CONFIG: cfg_d  = {2'b00, bus_wdata[5:0]};
                A_MODE:   mode_d = bus_wdata;
                A_SADRL:  sadr_d[7:0] = bus_wdata;
                A_FLAGS: begin
                    sadr_d[9:8] = bus_wdata[1:0];
                    if (bus_wdata[7]) rx_ovf_d = 1'b0;
                    if (bus_wdata[6]) tx_ovf_d = 1'b0;
                    if (bus_wdata[5]) tx_unf_d = 1'b0;
                end
                A_BCNT:   bcnt_d = bus_wdata;
                default: ;
            endcase
        end

        // TX FIFO
        if (tx_push_req && tx_full && !tx_byte_taken) tx_ovf_d = 1'b1;
        if (tx_byte_taken && tx_empty) tx_unf_d = 1'b1;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = bus_wdata;
            tx_wr_d = tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
        tx_cnt_d = tx_cnt_q + TXCW'(tx_push) - TXCW'(tx_pop);

        // RX path
`ifdef I2C_HOST_RX_FIFO_EN
        if (rx_byte_valid && rx_full && !rx_pop_req) rx_ovf_d = 1'b1;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = received_data;
            rx_wr_d = rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
        rx_cnt_d = rx_cnt_q + RXCW'(rx_push) - RXCW'(rx_pop);
`else
        if (rx_pop_req) rx_vld_d = 1'b0;
        if (rx_byte_valid) begin
            // Overwriting an unread byte loses data; a same-cycle read takes the old one.
            if (rx_vld_q && !rx_pop_req) rx_ovf_d = 1'b1;
            rx_byte_d = received_data;
            rx_vld_d  = 1'b1;
        end
`endif

        // Registered read port; rdata holds until the next read.
        if (rd_en) begin
            rvalid_d = 1'b1;
            case (bus_addr)
                A_CONFIG: rdata_d = cfg_q;
                A_MODE:   rdata_d = mode_q;
                A_SADRL:  rdata_d = sadr_q[7:0];
                A_FLAGS:  rdata_d = {rx_ovf_q, tx_ovf_q, tx_unf_q, rx_empty,
                                     rx_full, tx_empty, sadr_q[9:8]};
                A_BCNT:   rdata_d = bcnt_q;
                A_TXDATA: rdata_d = tx_head;
                A_RXDATA: rdata_d = rx_head;
                A_STATUS: rdata_d = cmd_status_reg;
                default:  rdata_d = 8'h00;
            endcase
        end
    end

    // State registers; reset empties both FIFOs and clears every flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg_q    <= '0;
            mode_q   <= '0;
            sadr_q   <= '0;
            bcnt_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            tx_unf_q <= 1'b0;
            tx_mem_q <= '0;
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_cnt_q <= '0;
`ifdef I2C_HOST_RX_FIFO_EN
            rx_mem_q <= '0;
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_cnt_q <= '0;
`else
            rx_byte_q <= '0;
            rx_vld_q  <= 1'b0;
`endif
        end else begin
            cfg_q    <= cfg_d;
            mode_q   <= mode_d;
            sadr_q   <= sadr_d;
            bcnt_q   <= bcnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            tx_unf_q <= tx_unf_d;
            tx_mem_q <= tx_mem_d;
            tx_rd_q  <= tx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_cnt_q <= tx_cnt_d;
`ifdef I2C_HOST_RX_FIFO_EN
            rx_mem_q <= rx_mem_d;
            rx_rd_q  <= rx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_cnt_q <= rx_cnt_d;
`else
            rx_byte_q <= rx_byte_d;
            rx_vld_q  <= rx_vld_d;
`endif
        end
    end

endmodule
